// File: rtl/tour_pkg.sv
// Shared constants, state encoding and command packing for the knight's-tour command sequencer.
package tour_pkg;

  localparam logic [3:0] OP_MOVE         = 4'h4;
  localparam logic [3:0] OP_MOVE_FANFARE = 4'h5;

  localparam logic [7:0] HEAD_N = 8'h00;
  localparam logic [7:0] HEAD_W = 8'h3F;
  localparam logic [7:0] HEAD_S = 8'h7F;
  localparam logic [7:0] HEAD_E = 8'hBF;

  localparam logic [7:0] RESP_ACK  = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;

  localparam int unsigned NUM_MOVES = 24;
  localparam logic [4:0]  LAST_MOVE = 5'(NUM_MOVES - 1);

  // Encodings kept identical to the legacy localparam values
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    VERT  = 3'd1,
    VWAIT = 3'd2,
    HORZ  = 3'd3,
    HWAIT = 3'd4
  } state_t;

  function automatic logic [15:0] mk_cmd(input logic [3:0] op, input logic [7:0] head,
                                         input logic [3:0] sq);
    return {op, head, sq};
  endfunction

endpackage

// File: rtl/tour_move_decode.sv
// Maps a one-hot knight move to its vertical and horizontal command words.
// Non-one-hot input decodes the lowest set bit (all-zero decodes as bit 0) and flags illegal.
import tour_pkg::*;

module tour_move_decode (
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd,
  output logic        illegal
);

  logic [2:0] sel;

  always_comb begin
    sel = '0;
    // Scan downward so the lowest set bit wins
    for (int unsigned i = 8; i > 0; i--) begin
      if (move[i-1]) sel = 3'(i - 1);
    end
    illegal = (move == '0) || ((move & (move - 8'd1)) != '0);

    vert_cmd = mk_cmd(OP_MOVE, HEAD_N, 4'd1);
    horz_cmd = mk_cmd(OP_MOVE_FANFARE, HEAD_E, 4'd2);
    case (sel)
      3'd0: begin vert_cmd = mk_cmd(OP_MOVE, HEAD_N, 4'd1); horz_cmd = mk_cmd(OP_MOVE_FANFARE, HEAD_E, 4'd2); end
      3'd1: begin vert_cmd = mk_cmd(OP_MOVE, HEAD_N, 4'd2); horz_cmd = mk_cmd(OP_MOVE_FANFARE, HEAD_E, 4'd1); end
      3'd2: begin vert_cmd = mk_cmd(OP_MOVE, HEAD_N, 4'd2); horz_cmd = mk_cmd(OP_MOVE_FANFARE, HEAD_W, 4'd1); end
      3'd3: begin vert_cmd = mk_cmd(OP_MOVE, HEAD_N, 4'd1); horz_cmd = mk_cmd(OP_MOVE_FANFARE, HEAD_W, 4'd2); end
      3'd4: begin vert_cmd = mk_cmd(OP_MOVE, HEAD_S, 4'd1); horz_cmd = mk_cmd(OP_MOVE_FANFARE, HEAD_W, 4'd2); end
      3'd5: begin vert_cmd = mk_cmd(OP_MOVE, HEAD_S, 4'd2); horz_cmd = mk_cmd(OP_MOVE_FANFARE, HEAD_W, 4'd1); end
      3'd6: begin vert_cmd = mk_cmd(OP_MOVE, HEAD_S, 4'd2); horz_cmd = mk_cmd(OP_MOVE_FANFARE, HEAD_E, 4'd1); end
      default: begin vert_cmd = mk_cmd(OP_MOVE, HEAD_S, 4'd1); horz_cmd = mk_cmd(OP_MOVE_FANFARE, HEAD_E, 4'd2); end
    endcase
  end

endmodule

// File: rtl/tour_cmd_seq.sv
// Replays a solved 24-move tour as vertical/horizontal command pairs, else passes UART commands through.
// Optional macro TOUR_CMD_ERR_EN adds the sticky err output for non-one-hot moves.
import tour_pkg::*;

module tour_cmd_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp,
  output logic        busy
`ifdef TOUR_CMD_ERR_EN
  ,
  output logic        err
`endif
);

  state_t      state;
  logic [15:0] vert_cmd;
  logic [15:0] horz_cmd;
  logic        bad_move;

  tour_move_decode u_decode (
    .move     (move),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd),
`ifdef TOUR_CMD_ERR_EN
    .illegal  (bad_move)
`else
    .illegal  ()
`endif
  );

`ifndef TOUR_CMD_ERR_EN
  assign bad_move = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mv_indx <= '0;
    end else begin
      case (state)
        IDLE: if (start_tour) begin
          state   <= VERT;
          mv_indx <= '0;
        end
        VERT: if (bad_move) begin
          state   <= IDLE;
          mv_indx <= '0;
        end else if (clr_cmd_rdy) begin
          state <= VWAIT;
        end
        VWAIT: if (send_resp) state <= HORZ;
        HORZ:  if (clr_cmd_rdy) state <= HWAIT;
        HWAIT: if (send_resp) begin
          if (mv_indx == LAST_MOVE) begin
            state   <= IDLE;
            mv_indx <= '0;
          end else begin
            state   <= VERT;
            mv_indx <= mv_indx + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TOUR_CMD_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          err <= 1'b0;
    else if (state == IDLE && start_tour) err <= 1'b0;
    else if (state == VERT && bad_move)   err <= 1'b1;
  end
`endif

  always_comb begin
    cmd     = cmd_UART;
    cmd_rdy = cmd_rdy_UART;
    resp    = RESP_ACK;
    busy    = 1'b0;
    case (state)
      VERT: begin
        cmd     = vert_cmd;
        cmd_rdy = !bad_move;
        resp    = RESP_BUSY;
        busy    = 1'b1;
      end
      VWAIT: begin
        cmd     = vert_cmd;
        cmd_rdy = 1'b0;
        resp    = RESP_BUSY;
        busy    = 1'b1;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        resp    = RESP_BUSY;
        busy    = 1'b1;
      end
      HWAIT: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b0;
        resp    = (mv_indx == LAST_MOVE) ? RESP_ACK : RESP_BUSY;
        busy    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Directed bench for tour_cmd_seq; build with TOUR_CMD_ERR_EN to exercise the err path.
module tb_tour_cmd_seq;

  logic        clk;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        busy;
`ifdef TOUR_CMD_ERR_EN
  logic        err;
`endif

  int total;
  int bad;
  int pulses;

  logic [15:0] exp_v [8];
  logic [15:0] exp_h [8];

  tour_cmd_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_tour   (start_tour),
    .move         (move),
    .mv_indx      (mv_indx),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .resp         (resp),
    .busy         (busy)
`ifdef TOUR_CMD_ERR_EN
    ,
    .err          (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic start();
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
  endtask

  // Entered in VERT; runs one full move and leaves on the following state
  task automatic do_move(input int k, input logic last);
    move = 8'h01 << k;
    #1;
    check("vert_cmd", cmd, exp_v[k]);
    check("vert_rdy", {15'b0, cmd_rdy}, 16'd1);
    if (cmd_rdy) pulses++;
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    #1;
    check("vwait_rdy", {15'b0, cmd_rdy}, 16'd0);
    check("vwait_resp", {8'b0, resp}, 16'h005A);
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    #1;
    check("horz_cmd", cmd, exp_h[k]);
    check("horz_rdy", {15'b0, cmd_rdy}, 16'd1);
    if (cmd_rdy) pulses++;
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    #1;
    check("hwait_rdy", {15'b0, cmd_rdy}, 16'd0);
    check("hwait_resp", {8'b0, resp}, last ? 16'h00A5 : 16'h005A);
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; pulses = 0;
    exp_v[0] = 16'h4001; exp_h[0] = 16'h5BF2;
    exp_v[1] = 16'h4002; exp_h[1] = 16'h5BF1;
    exp_v[2] = 16'h4002; exp_h[2] = 16'h53F1;
    exp_v[3] = 16'h4001; exp_h[3] = 16'h53F2;
    exp_v[4] = 16'h47F1; exp_h[4] = 16'h53F2;
    exp_v[5] = 16'h47F2; exp_h[5] = 16'h53F1;
    exp_v[6] = 16'h47F2; exp_h[6] = 16'h5BF1;
    exp_v[7] = 16'h47F1; exp_h[7] = 16'h5BF2;

    rst_n = 1'b0; start_tour = 1'b0; move = 8'h00; cmd_UART = 16'h0000;
    cmd_rdy_UART = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    #3;
    check("rst_indx", {11'b0, mv_indx}, 16'd0);
    check("rst_busy", {15'b0, busy}, 16'd0);
    check("rst_resp", {8'b0, resp}, 16'h00A5);
    check("rst_rdy", {15'b0, cmd_rdy}, 16'd0);
    do_reset();

    // IDLE pass-through
    cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1;
    #1;
    check("idle_cmd", cmd, 16'h1234);
    check("idle_rdy", {15'b0, cmd_rdy}, 16'd1);
    check("idle_resp", {8'b0, resp}, 16'h00A5);
    cmd_rdy_UART = 1'b0;

    // First move with ignored-input corner cases
    move = 8'h01;
    start();
    #1;
    check("v0_cmd", cmd, 16'h4001);
    check("v0_busy", {15'b0, busy}, 16'd1);
    check("v0_resp", {8'b0, resp}, 16'h005A);
    cmd_rdy_UART = 1'b1; start_tour = 1'b1;
    #1;
    check("v0_uart_ign", cmd, 16'h4001);
    tick();
    start_tour = 1'b0; cmd_rdy_UART = 1'b0;
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    #1;
    check("v0_send_ign", {15'b0, cmd_rdy}, 16'd1);
    clr_cmd_rdy = 1'b1; send_resp = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    #1;
    check("both_vwait_rdy", {15'b0, cmd_rdy}, 16'd0);
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    #1;
    check("h0_cmd", cmd, 16'h5BF2);
    check("h0_rdy", {15'b0, cmd_rdy}, 16'd1);
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    #1;
    check("h0_send_ign", {15'b0, cmd_rdy}, 16'd1);
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    tick();
    #1;
    check("hwait_clr_ign", {15'b0, cmd_rdy}, 16'd0);
    check("hwait_indx", {11'b0, mv_indx}, 16'd0);
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    check("indx_after_1", {11'b0, mv_indx}, 16'd1);

    // Move bit 5 from index 0
    do_reset();
    start();
    do_move(5, 1'b0);
    check("indx_b5", {11'b0, mv_indx}, 16'd1);

    // Full tour
    do_reset();
    start();
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      do_move(i % 8, i == 23);
    end
    #1;
    check("tour_pulses", 16'(pulses), 16'd48);
    check("tour_busy", {15'b0, busy}, 16'd0);
    check("tour_indx", {11'b0, mv_indx}, 16'd0);
    check("tour_resp", {8'b0, resp}, 16'h00A5);

    // Asynchronous reset in HORZ at index 7
    do_reset();
    start();
    for (int i = 0; i < 7; i++) do_move(i, 1'b0);
    move = 8'h80;
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    #1;
    check("horz7_indx", {11'b0, mv_indx}, 16'd7);
    check("horz7_cmd", cmd, 16'h5BF2);
    cmd_UART = 16'hBEEF; cmd_rdy_UART = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_indx", {11'b0, mv_indx}, 16'd0);
    check("arst_busy", {15'b0, busy}, 16'd0);
    check("arst_rdy", {15'b0, cmd_rdy}, 16'd1);
    check("arst_cmd", cmd, 16'hBEEF);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cmd_rdy_UART = 1'b0;

`ifdef TOUR_CMD_ERR_EN
    move = 8'h03;
    start();
    #1;
    check("err_rdy", {15'b0, cmd_rdy}, 16'd0);
    tick();
    check("err_set", {15'b0, err}, 16'd1);
    check("err_idle", {15'b0, busy}, 16'd0);
    move = 8'h01;
    start();
    check("err_clr", {15'b0, err}, 16'd0);
    check("err_restart", {15'b0, busy}, 16'd1);
`else
    move = 8'h06;
    start();
    #1;
    check("multi_low", cmd, 16'h4002);
    move = 8'h00;
    #1;
    check("zero_b0", cmd, 16'h4001);
    check("zero_rdy", {15'b0, cmd_rdy}, 16'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
